evt_pulse_gen: RTL and testbench
================================

EVT_PULSE_GEN -- requirements
Module: evt_pulse_gen

Interface
REQ-001 Parameter N_CH, default 4, number of independent edge-detect channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per channel (2..4).
REQ-003 Parameter DEB_W, default 4, width of debounce length and counter.
REQ-004 Parameter PERIOD_W, default 16, width of tick period and counter.
REQ-005 clk  input  1  clock; all logic SHALL be in this single clock domain.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pulse_en  input  1  tick generator enable.
REQ-008 period  input  PERIOD_W  tick period in clk cycles, runtime programmable.
REQ-009 deb_len  input  DEB_W  debounce length in cycles, shared by all channels.
REQ-010 data_in  input  N_CH  asynchronous data inputs.
REQ-011 evt_clr  input  N_CH  per-channel sticky flag clear, one-cycle pulse.
REQ-012 tick  output  1  periodic one-cycle pulse.
REQ-013 level  output  N_CH  debounced, synchronized level per channel.
REQ-014 redge  output  N_CH  one-cycle rising-edge pulse of level.
REQ-015 fedge  output  N_CH  one-cycle falling-edge pulse of level.
REQ-016 evt_flag  output  N_CH  sticky edge-seen flag per channel.

Function
REQ-017 Tick counter SHALL count 0..period-1 and wrap to 0; tick SHALL be registered, high exactly in the cycle after the counter holds period-1; period is exact, not rounded to a power of two.
REQ-018 period=0 SHALL hold counter at 0 and tick low; period=1 SHALL drive tick high every cycle while pulse_en=1.
REQ-019 pulse_en=0 SHALL clear the counter and force tick low next cycle; first tick after enable SHALL occur period cycles after pulse_en rises.
REQ-020 If period is lowered so counter >= new period-1, counter SHALL wrap (tick asserted) on the next cycle; no overrun past 2^PERIOD_W-1.
REQ-021 Each channel SHALL pass data_in through SYNC_STAGES flops before any other use.
REQ-022 Debounce: counter increments each cycle synchronized value != level, clears when equal; when counter == deb_len, level SHALL take the synchronized value and counter SHALL clear.
REQ-023 deb_len=0 SHALL give level = synchronized value one cycle later; total latency data_in to level = SYNC_STAGES+1+deb_len cycles for a stable input.
REQ-024 A glitch shorter than deb_len+1 synchronized cycles SHALL NOT change level nor produce an edge.
REQ-025 redge/fedge SHALL be registered and asserted in the same cycle level changes, exactly one cycle wide; never both high on a channel.
REQ-026 evt_flag[i] SHALL set on redge[i] or fedge[i] and clear on evt_clr[i]; simultaneous set and clear SHALL leave the flag set.
REQ-027 deb_len changed mid-count SHALL take effect on the next compare; counter >= new deb_len SHALL update level next cycle.
REQ-028 Channels SHALL be fully independent; edges on multiple channels in one cycle SHALL all be reported.

Reset
REQ-029 On rst_n low all flops SHALL clear asynchronously: tick, level, redge, fedge, evt_flag, synchronizers, and counters = 0.
REQ-030 Reset release with data_in=1 SHALL produce one redge per such channel after REQ-023 latency.
REQ-031 Reset mid-debounce or mid-period SHALL abandon the count; no tick or edge SHALL emerge from pre-reset state.

Structure
REQ-032 Package evt_pulse_pkg SHALL hold parameter range limits and default constants for N_CH, SYNC_STAGES, DEB_W, PERIOD_W.
REQ-033 Sub-module evt_chan SHALL implement one channel (sync, debounce, edge, sticky flag), instantiated N_CH times via generate.
REQ-034 Tick generator SHALL reside in the top level; RTL target 120-400 lines total.

Verification
REQ-035 period=5, pulse_en=1 for 30 cycles -> tick high on cycles 5,10,15,20,25,30 only; period=1 -> tick constant high; period=0 -> tick never high.
REQ-036 Counter at 8 with period=10, period changed to 4 -> tick next cycle, then every 4 cycles.
REQ-037 SYNC_STAGES=2, deb_len=3, data_in[0] rises and holds -> level[0] and redge[0] high 6 cycles later, redge one cycle wide, evt_flag[0] set.
REQ-038 deb_len=3, data_in[1] pulsed high 2 cycles -> no level change, no edge, evt_flag[1] stays 0.
REQ-039 fedge[2] and evt_clr[2] in same cycle -> evt_flag[2]=1; evt_clr[2] alone next cycle -> evt_flag[2]=0.
REQ-040 rst_n asserted mid-debounce with data_in=4'hF -> all outputs 0 immediately; after release, four redge pulses in same cycle after REQ-023 latency.

Source files
------------

// File: rtl/evt_pulse_pkg.sv
// Shared limits and defaults for the event/pulse generator slice.
// Channel, synchronizer and counter widths are bounded here.
package evt_pulse_pkg;

  localparam int N_CH_MIN     = 1;
  localparam int N_CH_MAX     = 32;
  localparam int N_CH_DEF     = 4;

  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 4;
  localparam int SYNC_DEF     = 2;

  localparam int DEB_W_MIN    = 1;
  localparam int DEB_W_DEF    = 4;

  localparam int PERIOD_W_MIN = 1;
  localparam int PERIOD_W_DEF = 16;

endpackage

// File: rtl/evt_pulse_gen_chan.sv
// One input channel: synchronizer, debounce filter,
// registered edge pulses and a sticky edge-seen flag.
module evt_chan
  import evt_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEB_W-1:0] deb_len,
  input  logic             data_in,
  input  logic             evt_clr,
  output logic             level,
  output logic             redge,
  output logic             fedge,
  output logic             evt_flag
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   redge_q, redge_d;
  logic                   fedge_q, fedge_d;
  logic                   flag_q, flag_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], data_in};
    cnt_d   = '0;
    level_d = level_q;
    redge_d = 1'b0;
    fedge_d = 1'b0;
    // a set from last cycle's edge beats a same-cycle clear
    flag_d  = redge_q | fedge_q | (flag_q & ~evt_clr);
    if (s != level_q) begin
      if (cnt_q >= deb_len) begin
        level_d = s;
        redge_d = s;
        fedge_d = ~s;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      redge_q <= 1'b0;
      fedge_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      redge_q <= redge_d;
      fedge_q <= fedge_d;
      flag_q  <= flag_d;
    end
  end

  assign level    = level_q;
  assign redge    = redge_q;
  assign fedge    = fedge_q;
  assign evt_flag = flag_q;

endmodule

// File: rtl/evt_pulse_gen.sv
// Periodic tick generator plus N_CH debounced edge-detect
// channels, all in the clk domain.
module evt_pulse_gen
  import evt_pulse_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DEB_W       = DEB_W_DEF,
  parameter int PERIOD_W    = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DEB_W-1:0]    deb_len,
  input  logic [N_CH-1:0]     data_in,
  input  logic [N_CH-1:0]     evt_clr,
  output logic                tick,
  output logic [N_CH-1:0]     level,
  output logic [N_CH-1:0]     redge,
  output logic [N_CH-1:0]     fedge,
  output logic [N_CH-1:0]     evt_flag
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] last;
  logic                tick_q, tick_d;

  assign last = period - PERIOD_W'(1);

  // >= rather than == so a shrunk period wraps at once
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (pulse_en && period != '0) begin
      if (cnt_q >= last) begin
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    evt_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .deb_len  (deb_len),
      .data_in  (data_in[i]),
      .evt_clr  (evt_clr[i]),
      .level    (level[i]),
      .redge    (redge[i]),
      .fedge    (fedge[i]),
      .evt_flag (evt_flag[i])
    );
  end

endmodule

// File: tb/tb_evt_pulse_gen.sv
// Directed and randomized checks of evt_pulse_gen against
// a window/arith reference model.
module tb_evt_pulse_gen;

  localparam int N_CH     = 4;
  localparam int S        = 2;
  localparam int DEB_W    = 4;
  localparam int PERIOD_W = 16;

  logic                clk;
  logic                rst_n;
  logic                pulse_en;
  logic [PERIOD_W-1:0] period;
  logic [DEB_W-1:0]    deb_len;
  logic [N_CH-1:0]     data_in;
  logic [N_CH-1:0]     evt_clr;
  logic                tick;
  logic [N_CH-1:0]     level;
  logic [N_CH-1:0]     redge;
  logic [N_CH-1:0]     fedge;
  logic [N_CH-1:0]     evt_flag;

  int checks = 0;
  int errors = 0;

  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_lvl, m_re, m_fe, m_flg;
  int              en_run;
  int              p_int, d_int;

  evt_pulse_gen #(
    .N_CH        (N_CH),
    .SYNC_STAGES (S),
    .DEB_W       (DEB_W),
    .PERIOD_W    (PERIOD_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_en (pulse_en),
    .period   (period),
    .deb_len  (deb_len),
    .data_in  (data_in),
    .evt_clr  (evt_clr),
    .tick     (tick),
    .level    (level),
    .redge    (redge),
    .fedge    (fedge),
    .evt_flag (evt_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // synchronized sample seen by the debouncer at edge m
  function automatic logic samp(int m, int ch);
    if (m - S < 1) return 1'b0;
    return hist[m-S-1][ch];
  endfunction

  initial begin
    rst_n    = 1'b1;
    pulse_en = 1'b0;
    period   = '0;
    deb_len  = '0;
    data_in  = '0;
    evt_clr  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_level", level, 0);
    chk("rst_redge", redge, 0);
    chk("rst_fedge", fedge, 0);
    chk("rst_flag", evt_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // period 5, then 1, then 0
    period = 16'd5;
    do_reset();
    pulse_en = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk("p5_tick", tick, (c % 5 == 0));
    end
    period = 16'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("p1_tick", tick, 1);
    end
    period = 16'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("p0_tick", tick, 0);
    end

    // shrink period 10 -> 4 with counter at 8
    pulse_en = 1'b0;
    period   = 16'd10;
    @(negedge clk);
    chk("dis_tick", tick, 0);
    pulse_en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      chk("p10_tick", tick, 0);
    end
    period = 16'd4;
    for (int e = 9; e <= 17; e++) begin
      @(negedge clk);
      chk("shrink_tick", tick, ((e - 9) % 4 == 0));
    end

    // ch0 rise, deb_len 3: latency 6
    pulse_en = 1'b0;
    deb_len  = 4'd3;
    data_in  = '0;
    do_reset();
    data_in[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      chk("ch0_level", level[0], (e == 6));
      chk("ch0_redge", redge[0], (e == 6));
    end
    @(negedge clk);
    chk("ch0_redge_w", redge[0], 0);
    chk("ch0_fedge", fedge[0], 0);
    chk("ch0_level_h", level[0], 1);
    chk("ch0_flag", evt_flag[0], 1);

    // ch1 two-cycle glitch is filtered
    for (int e = 1; e <= 12; e++) begin
      data_in[1] = (e <= 2);
      @(negedge clk);
      chk("gl_level", level[1], 0);
      chk("gl_edge", redge[1] | fedge[1], 0);
      chk("gl_flag", evt_flag[1], 0);
    end

    // deb_len lowered mid-count on ch3
    deb_len    = 4'd7;
    data_in[3] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      chk("dl_level_lo", level[3], 0);
    end
    deb_len = 4'd2;
    @(negedge clk);
    chk("dl_level_hi", level[3], 1);

    // ch2 set/clear priority
    deb_len    = 4'd0;
    data_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("sc_flag_set", evt_flag[2], 1);
    evt_clr[2] = 1'b1;
    @(negedge clk);
    chk("sc_flag_clr", evt_flag[2], 0);
    evt_clr[2] = 1'b0;
    data_in[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("sc_fedge_lo", fedge[2], 0);
    end
    @(negedge clk);
    chk("sc_fedge", fedge[2], 1);
    chk("sc_redge", redge[2], 0);
    evt_clr[2] = 1'b1;
    @(negedge clk);
    chk("sc_both", evt_flag[2], 1);
    chk("sc_fedge_w", fedge[2], 0);
    @(negedge clk);
    chk("sc_clr_only", evt_flag[2], 0);
    evt_clr[2] = 1'b0;

    // reset mid-debounce with all inputs high
    deb_len  = 4'd3;
    period   = 16'd5;
    pulse_en = 1'b1;
    data_in  = 4'hF;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_tick", tick, 0);
    chk("mr_level", level, 0);
    chk("mr_redge", redge, 0);
    chk("mr_fedge", fedge, 0);
    chk("mr_flag", evt_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      chk("mr_redge_n", redge, (e == 6) ? 4'hF : 4'h0);
      chk("mr_tick_n", tick, (e == 5));
    end
    @(negedge clk);
    chk("mr_level_n", level, 4'hF);
    chk("mr_redge_w", redge, 0);
    chk("mr_flag_n", evt_flag, 4'hF);

    // randomized rounds against the reference model
    for (int r = 0; r < 6; r++) begin
      p_int    = $urandom_range(0, 7);
      d_int    = $urandom_range(0, 3);
      period   = PERIOD_W'(p_int);
      deb_len  = DEB_W'(d_int);
      pulse_en = 1'b1;
      data_in  = '0;
      evt_clr  = '0;
      do_reset();
      hist.delete();
      en_run = 0;
      m_lvl  = '0;
      m_re   = '0;
      m_fe   = '0;
      m_flg  = '0;
      for (int n = 1; n <= 250; n++) begin
        data_in  = data_in ^ N_CH'($urandom_range(0, 15)
                   & $urandom_range(0, 15));
        evt_clr  = N_CH'($urandom_range(0, 15)
                   & $urandom_range(0, 15)
                   & $urandom_range(0, 15));
        pulse_en = ($urandom_range(0, 9) != 0);
        hist.push_back(data_in);
        @(negedge clk);
        en_run = pulse_en ? en_run + 1 : 0;
        m_flg  = m_re | m_fe | (m_flg & ~evt_clr);
        for (int ch = 0; ch < N_CH; ch++) begin
          logic v;
          bit   ok;
          v  = samp(n, ch);
          ok = 1'b1;
          for (int m = n - d_int; m < n; m++)
            if (samp(m, ch) != v) ok = 1'b0;
          m_re[ch] = 1'b0;
          m_fe[ch] = 1'b0;
          if (ok && v != m_lvl[ch]) begin
            m_lvl[ch] = v;
            m_re[ch]  = v;
            m_fe[ch]  = ~v;
          end
        end
        chk("rnd_tick", tick,
            (pulse_en && p_int != 0
             && (en_run % (p_int == 0 ? 1 : p_int)) == 0));
        chk("rnd_level", level, m_lvl);
        chk("rnd_redge", redge, m_re);
        chk("rnd_fedge", fedge, m_fe);
        chk("rnd_flag", evt_flag, m_flg);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
